vec_out_mem: RTL and testbench
==============================

VEC_OUT_MEM -- requirements
Module: vec_out_mem

Interface
REQ-001 Parameter WIDTH, default 24: bits per element.
REQ-002 Parameter LANES, default 4: elements per vector access.
REQ-003 Parameter DEPTH, default 10000: element capacity; SHALL be a multiple of LANES.
REQ-004 Parameter BASE, default 24: first element address mapped to this memory.
REQ-005 Parameter ADDR_W, default 24: address width.
REQ-006 clk  in  1  sole clock; all logic on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 we  in  1  vector write strobe.
REQ-009 address  in  ADDR_W  element address of lane 0; lane i targets address+i.
REQ-010 wd  in  LANES*WIDTH  write data, lane i at bits [i*WIDTH +: WIDTH].
REQ-011 lane_mask  in  LANES  per-lane write enable, qualified by we.
REQ-012 rd  out  LANES*WIDTH  registered read data, same lane packing.
REQ-013 hit  out  LANES  registered per-lane in-window flag for the last access.
REQ-014 drain_start  in  1  request a sequential dump of the whole memory.
REQ-015 drain_busy  out  1  drain in progress.
REQ-016 drain_valid / drain_ready  out / in  1 / 1  drain stream handshake.
REQ-017 drain_data  out  WIDTH  element at index drain_idx.
REQ-018 drain_idx  out  ADDR_W  offset (0..DEPTH-1) of drain_data.
REQ-019 drain_done  out  1  one-cycle pulse after the last element is accepted.
REQ-020 wr_drop  out  1  sticky flag: a write arrived while drain_busy.

Function
REQ-021 Lane i is in-window iff BASE <= address+i < BASE+DEPTH, evaluated at full ADDR_W+1 width (no wrap).
REQ-022 Write: on posedge with we, lane_mask[i]=1, lane in-window and drain_busy=0, element (address+i-BASE) <- lane i data; other lanes untouched.
REQ-023 Storage SHALL be LANES interleaved banks: element e lives in bank e mod LANES, row e / LANES; any LANES consecutive addresses hit distinct banks with one access each.
REQ-024 Read: rd and hit register one cycle after address is presented (latency 1); out-of-window lanes return 0 with hit[i]=0.
REQ-025 Same-cycle write and read of one element returns the old value.
REQ-026 While drain_busy, rd SHALL read 0 and hit 0; writes are discarded and set wr_drop (cleared only by rst).
REQ-027 Drain FSM states IDLE, FETCH, SEND, DONE.
REQ-028 IDLE: drain_start -> FETCH, drain_idx=0; drain_start in any other state is ignored.
REQ-029 FETCH: read element drain_idx (one cycle) -> SEND.
REQ-030 SEND: drain_valid=1, drain_data/drain_idx stable until drain_ready; on handshake, if drain_idx=DEPTH-1 -> DONE, else drain_idx+1 -> FETCH.
REQ-031 DONE: drain_done=1 for exactly one cycle -> IDLE.
REQ-032 drain_busy=1 in FETCH, SEND, DONE.
REQ-033 drain_valid SHALL never drop without a handshake, except on rst.

Reset
REQ-034 On rst: FSM IDLE; drain_idx, drain_data, rd, hit = 0; drain_valid, drain_busy, drain_done, wr_drop = 0.
REQ-035 Memory contents SHALL NOT be cleared by rst.
REQ-036 rst mid-drain aborts immediately; no drain_done pulse.

Structure
REQ-037 Package vec_out_mem_pkg holds the drain state enum and default WIDTH/LANES/DEPTH/BASE constants.
REQ-038 One sub-module, out_mem_bank (1 write, 1 read port, registered read), instantiated LANES times; lane-to-bank rotation and drain/host read mux live in the top.

Verification (WIDTH=24, LANES=4, DEPTH=16, BASE=24)
REQ-039 we=1, address=24, mask=1111, wd={4,3,2,1} (lane 3..0); next cycle read 24 -> rd={4,3,2,1}, hit=1111.
REQ-040 Write address=38, mask=1111 -> only elements 14,15 written; read 38 -> hit=0011, upper two lanes rd=0.
REQ-041 Write address=25, mask=0101 -> elements 1 and 3 updated, 2 and 4 unchanged (bank rotation check).
REQ-042 Fill 0..15 with value=index, drain_start, drain_ready toggling 1/0 -> 16 beats in order, idx 0..15, data stable while stalled, single drain_done.
REQ-043 drain_start, assert rst after 5 handshakes -> drain_valid=0, FSM IDLE, no drain_done; memory retains data on re-drain.
REQ-044 we=1 during drain_busy at address 24 -> element 0 unchanged, wr_drop=1 until rst.

Source files
------------

// File: rtl/vec_out_mem_pkg.sv
// Shared definitions for the vector output memory.
// Holds the default geometry constants, the drain FSM state type and a small
// width helper used for index sizing.
package vec_out_mem_pkg;

  localparam int unsigned DefWidth = 24;
  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefDepth = 10000;
  localparam int unsigned DefBase  = 24;
  localparam int unsigned DefAddrW = 24;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StDone
  } drain_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_mem_bank.sv
// One storage bank of the vector output memory.
// Ports:
//   clk_i    clock, posedge
//   we_i     write enable
//   waddr_i  write row
//   wdata_i  write data
//   raddr_i  read row
//   rdata_o  registered read data (read-before-write on a same-row collision)
// Contents are not reset.
module out_mem_bank #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned ROWS  = 2500,
  parameter int unsigned ROW_W = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ROW_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [ROW_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ROWS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vec_out_mem.sv
// Windowed, lane-interleaved vector memory with a sequential drain port.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   we, address, wd     vector write strobe, lane-0 element address, packed lane data
//   lane_mask           per-lane write enable
//   rd, hit             read data and per-lane in-window flag, one cycle after address
//   drain_start         begin dumping every element in order
//   drain_busy          drain in progress (host access blocked)
//   drain_valid/ready   drain stream handshake
//   drain_data/idx      element value and its offset
//   drain_done          one-cycle pulse after the last beat
//   wr_drop             sticky: a write was attempted while draining
module vec_out_mem
  import vec_out_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned LANES  = DefLanes,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned BASE   = DefBase,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      address,
  input  logic [LANES*WIDTH-1:0] wd,
  input  logic [LANES-1:0]       lane_mask,
  output logic [LANES*WIDTH-1:0] rd,
  output logic [LANES-1:0]       hit,
  input  logic                   drain_start,
  output logic                   drain_busy,
  output logic                   drain_valid,
  input  logic                   drain_ready,
  output logic [WIDTH-1:0]       drain_data,
  output logic [ADDR_W-1:0]      drain_idx,
  output logic                   drain_done,
  output logic                   wr_drop
);

  localparam int unsigned Rows  = DEPTH / LANES;
  localparam int unsigned RowW  = clog2_min1(Rows);
  localparam int unsigned BankW = clog2_min1(LANES);
  // One extra bit so address+i never wraps back into the window.
  localparam int unsigned ExtW  = ADDR_W + 1;
  localparam logic [ExtW-1:0]   BaseExt = ExtW'(BASE);
  localparam logic [ExtW-1:0]   EndExt  = ExtW'(BASE + DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  drain_state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LANES-1:0]  hit_q, hit_d;
  logic              wr_drop_q;
  logic [LANES-1:0][BankW-1:0] rd_bank_q;

  logic [LANES-1:0][ExtW-1:0]  lane_addr;
  logic [LANES-1:0][ExtW-1:0]  lane_off;
  logic [LANES-1:0]            lane_in_win;
  logic [LANES-1:0][BankW-1:0] lane_bank;
  logic [LANES-1:0][RowW-1:0]  lane_row;

  logic [LANES-1:0]            bank_we;
  logic [LANES-1:0][RowW-1:0]  bank_addr;
  logic [LANES-1:0][WIDTH-1:0] bank_wdata;
  logic [LANES-1:0][WIDTH-1:0] bank_rdata;

  logic [RowW-1:0]  drain_row;
  logic [BankW-1:0] drain_bank;

  assign drain_busy = (state_q != StIdle);
  assign drain_row  = RowW'(idx_q / ADDR_W'(LANES));
  assign drain_bank = BankW'(idx_q % ADDR_W'(LANES));

  // Per-lane window test and element -> (bank, row) mapping.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i]   = {1'b0, address} + ExtW'(i);
      lane_in_win[i] = (lane_addr[i] >= BaseExt) && (lane_addr[i] < EndExt);
      lane_off[i]    = lane_addr[i] - BaseExt;
      lane_bank[i]   = BankW'(lane_off[i] % ExtW'(LANES));
      lane_row[i]    = RowW'(lane_off[i] / ExtW'(LANES));
    end
  end

  // Route each in-window lane to its bank; consecutive lanes never share a bank.
  // While draining every bank reads the current drain row instead.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      bank_we[k]    = 1'b0;
      bank_addr[k]  = '0;
      bank_wdata[k] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (lane_in_win[i] && (lane_bank[i] == BankW'(k))) begin
          bank_addr[k]  = lane_row[i];
          bank_wdata[k] = wd[i*WIDTH +: WIDTH];
          bank_we[k]    = we & lane_mask[i] & ~drain_busy;
        end
      end
      if (drain_busy) begin
        bank_addr[k] = drain_row;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    out_mem_bank #(
      .WIDTH(WIDTH),
      .ROWS (Rows),
      .ROW_W(RowW)
    ) u_bank (
      .clk_i  (clk),
      .we_i   (bank_we[g]),
      .waddr_i(bank_addr[g]),
      .wdata_i(bank_wdata[g]),
      .raddr_i(bank_addr[g]),
      .rdata_o(bank_rdata[g])
    );
  end

  // Drain FSM next state and outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drain_valid = 1'b0;
    drain_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (drain_start) begin
          state_d = StFetch;
          idx_d   = '0;
        end
      end
      StFetch: state_d = StSend;
      StSend: begin
        drain_valid = 1'b1;
        if (drain_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        drain_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A host read only returns data if the drain is idle now and next cycle.
  assign hit_d = lane_in_win & {LANES{(state_q == StIdle) && (state_d == StIdle)}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      hit_q     <= '0;
      rd_bank_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      rd_bank_q <= lane_bank;
      wr_drop_q <= wr_drop_q | (we & drain_busy);
    end
  end

  // Bank read data is held during SEND because the drain row does not move.
  assign drain_data = (state_q == StSend) ? bank_rdata[drain_bank] : '0;
  assign drain_idx  = idx_q;
  assign hit        = hit_q;
  assign wr_drop    = wr_drop_q;

  always_comb begin
    rd = '0;
    for (int i = 0; i < LANES; i++) begin
      rd[i*WIDTH +: WIDTH] = hit_q[i] ? bank_rdata[rd_bank_q[i]] : '0;
    end
  end

endmodule

// File: tb/tb_vec_out_mem.sv
module tb_vec_out_mem;

  localparam int W = 24;
  localparam int L = 4;
  localparam int D = 16;
  localparam int B = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [23:0]   address;
  logic [95:0]   wd;
  logic [3:0]    lane_mask;
  logic [95:0]   rd;
  logic [3:0]    hit;
  logic          drain_start;
  logic          drain_busy;
  logic          drain_valid;
  logic          drain_ready;
  logic [23:0]   drain_data;
  logic [23:0]   drain_idx;
  logic          drain_done;
  logic          wr_drop;

  vec_out_mem #(
    .WIDTH (W),
    .LANES (L),
    .DEPTH (D),
    .BASE  (B),
    .ADDR_W(24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .address    (address),
    .wd         (wd),
    .lane_mask  (lane_mask),
    .rd         (rd),
    .hit        (hit),
    .drain_start(drain_start),
    .drain_busy (drain_busy),
    .drain_valid(drain_valid),
    .drain_ready(drain_ready),
    .drain_data (drain_data),
    .drain_idx  (drain_idx),
    .drain_done (drain_done),
    .wr_drop    (wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] rd;
    logic [3:0]  hit;
  } rd_exp_t;

  typedef struct {
    logic [23:0] idx;
    logic [23:0] data;
  } drain_exp_t;

  rd_exp_t    rd_q[$];
  drain_exp_t drain_q[$];
  logic [23:0] mem_m [D];

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [95:0] pack4(input int v3, input int v2, input int v1, input int v0);
    return {v3[23:0], v2[23:0], v1[23:0], v0[23:0]};
  endfunction

  // Reference: lane i reads element address+i-BASE when that lies in [0, DEPTH).
  task automatic model_read(input logic [23:0] a, input bit busy,
                            output logic [95:0] r, output logic [3:0] h);
    r = '0;
    h = '0;
    if (!busy) begin
      for (int i = 0; i < L; i++) begin
        longint el = longint'(a) + i - B;
        if (el >= 0 && el < D) begin
          h[i] = 1'b1;
          r[i*W +: W] = mem_m[el];
        end
      end
    end
  endtask

  task automatic access(input logic w, input logic [23:0] a, input logic [95:0] d,
                        input logic [3:0] m, input bit c, input bit busy);
    logic [95:0] er;
    logic [3:0]  eh;
    we = w;
    address = a;
    wd = d;
    lane_mask = m;
    @(posedge clk);
    if (c) begin
      model_read(a, busy, er, eh);
      rd_q.push_back('{rd: er, hit: eh});
    end
    if (w && !busy) begin
      for (int i = 0; i < L; i++) begin
        longint el = longint'(a) + i - B;
        if (m[i] && el >= 0 && el < D) mem_m[el] = d[i*W +: W];
      end
    end
    #1;
    we = 1'b0;
    lane_mask = '0;
    drain_start = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [23:0] prev_data = '0;
  logic [23:0] prev_idx = '0;
  rd_exp_t     rexp;
  drain_exp_t  dexp;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_q.size() > 0) begin
        rexp = rd_q.pop_front();
        chk("rd", rd, rexp.rd);
        chk("hit", {92'd0, hit}, {92'd0, rexp.hit});
      end
      if (drain_busy) begin
        chk("busy_hit_zero", {92'd0, hit}, 96'd0);
        chk("busy_rd_zero", rd, 96'd0);
      end
      if (prev_valid && !prev_ready) begin
        chk("valid_hold", {95'd0, drain_valid}, 96'd1);
        chk("data_hold", {72'd0, drain_data}, {72'd0, prev_data});
        chk("idx_hold", {72'd0, drain_idx}, {72'd0, prev_idx});
      end
      if (drain_valid && drain_ready) begin
        hs_count++;
        if (drain_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got idx %0h want none", drain_idx);
        end else begin
          dexp = drain_q.pop_front();
          chk("drain_idx", {72'd0, drain_idx}, {72'd0, dexp.idx});
          chk("drain_data", {72'd0, drain_data}, {72'd0, dexp.data});
        end
      end
      if (drain_done) done_count++;
    end
    prev_valid = drain_valid && !rst;
    prev_ready = drain_ready;
    prev_data  = drain_data;
    prev_idx   = drain_idx;
  end

  task automatic run_drain(input int abort_after, input bit host_write);
    int hs0;
    int done0;
    int cyc;
    bit aborted;
    drain_q.delete();
    for (int e = 0; e < D; e++) drain_q.push_back('{idx: 24'(e), data: mem_m[e]});
    hs0 = hs_count;
    done0 = done_count;
    aborted = 1'b0;
    drain_start = 1'b1;
    access(1'b0, '0, '0, '0, 1'b0, 1'b0);
    cyc = 0;
    while (done_count == done0 && cyc < 400 && !aborted) begin
      drain_ready = 1'($urandom_range(0, 1));
      if (host_write && cyc == 3) access(1'b1, 24'd24, {4{24'h5A5A5A}}, 4'hF, 1'b1, 1'b1);
      else access(1'b0, '0, '0, '0, 1'b0, 1'b1);
      cyc++;
      if (abort_after > 0 && (hs_count - hs0) >= abort_after) aborted = 1'b1;
    end
    drain_ready = 1'b0;
    if (aborted) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_valid", {95'd0, drain_valid}, 96'd0);
      chk("abort_busy", {95'd0, drain_busy}, 96'd0);
      chk("abort_no_done", 96'(done_count), 96'(done0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      drain_q.delete();
    end else begin
      chk("drain_done_seen", 96'(done_count), 96'(done0 + 1));
      chk("drain_all_beats", 96'(drain_q.size()), 96'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_single_done", 96'(done_count), 96'(done0 + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    we = 1'b0;
    address = '0;
    wd = '0;
    lane_mask = '0;
    drain_start = 1'b0;
    drain_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", rd, 96'd0);
    chk("rst_hit", {92'd0, hit}, 96'd0);
    chk("rst_valid", {95'd0, drain_valid}, 96'd0);
    chk("rst_busy", {95'd0, drain_busy}, 96'd0);
    chk("rst_done", {95'd0, drain_done}, 96'd0);
    chk("rst_wr_drop", {95'd0, wr_drop}, 96'd0);
    chk("rst_idx", {72'd0, drain_idx}, 96'd0);
    chk("rst_data", {72'd0, drain_data}, 96'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Known contents everywhere before any reads.
    for (int k = 0; k < D / L; k++) begin
      access(1'b1, 24'(B + 4 * k), pack4(103 + 4 * k, 102 + 4 * k, 101 + 4 * k, 100 + 4 * k),
             4'hF, 1'b0, 1'b0);
    end

    // Aligned full write then read back.
    access(1'b1, 24'd24, pack4(4, 3, 2, 1), 4'hF, 1'b0, 1'b0);
    access(1'b0, 24'd24, '0, '0, 1'b1, 1'b0);
    // Top edge: only elements 14 and 15 are in window.
    access(1'b1, 24'd38, pack4(24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD), 4'hF, 1'b0, 1'b0);
    access(1'b0, 24'd38, '0, '0, 1'b1, 1'b0);
    // Unaligned masked write across a bank rotation.
    access(1'b1, 24'd25, pack4(24'h111111, 24'h222222, 24'h333333, 24'h444444), 4'b0101,
           1'b0, 1'b0);
    access(1'b0, 24'd24, '0, '0, 1'b1, 1'b0);
    access(1'b0, 24'd28, '0, '0, 1'b1, 1'b0);
    // Window boundaries, including no wrap at the top of the address space.
    access(1'b0, 24'hFFFFFE, '0, '0, 1'b1, 1'b0);
    access(1'b0, 24'd21, '0, '0, 1'b1, 1'b0);
    access(1'b0, 24'd23, '0, '0, 1'b1, 1'b0);
    access(1'b0, 24'd37, '0, '0, 1'b1, 1'b0);
    access(1'b0, 24'd40, '0, '0, 1'b1, 1'b0);
    access(1'b0, 24'd0, '0, '0, 1'b1, 1'b0);

    // Random mixed traffic, including same-cycle write/read collisions.
    for (int n = 0; n < 200; n++) begin
      logic [95:0] d;
      d = {$urandom, $urandom, $urandom};
      access(1'($urandom_range(0, 1)), 24'(B - 6 + $urandom_range(0, D + 8)), d,
             4'($urandom_range(0, 15)), 1'b1, 1'b0);
    end

    // Fill with value = index and drain.
    for (int k = 0; k < D / L; k++) begin
      access(1'b1, 24'(B + 4 * k), pack4(4 * k + 3, 4 * k + 2, 4 * k + 1, 4 * k), 4'hF,
             1'b0, 1'b0);
    end
    run_drain(0, 1'b0);

    // Abort after five beats, then a full drain must still see the data.
    run_drain(5, 1'b0);
    run_drain(0, 1'b0);

    // Write during a drain is dropped and flagged.
    run_drain(0, 1'b1);
    access(1'b0, 24'd24, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("wr_drop_set", {95'd0, wr_drop}, 96'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("wr_drop_cleared", {95'd0, wr_drop}, 96'd0);
    chk("rd_queue_empty", 96'(rd_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
